// File: rtl/nibble_serial_addsub.sv
// nibble_serial_addsub: multi-cycle add/subtract that time-shares one 4-bit
// ripple-carry slice across NIBBLES nibbles, LSB nibble first.
// Ports:
//   i_clk    rising-edge clock
//   i_rst_n  synchronous active-low reset
//   i_start  request, accepted in IDLE or DONE
//   i_sub    0 = a+b, 1 = a-b (sampled with start)
//   i_a/i_b  operands, 4*NIBBLES bits (sampled with start)
//   o_busy   high while nibbles are processed
//   o_done   one-cycle pulse, results valid in the same cycle
//   o_sum    registered result
//   o_c_out  carry out of MSB nibble (sub: 1 = no borrow)
//   o_ovf    signed two's-complement overflow
//   o_zero   result is zero
module nibble_serial_addsub #(
    parameter int unsigned NIBBLES = 4
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_start,
    input  logic                   i_sub,
    input  logic [4*NIBBLES-1:0]   i_a,
    input  logic [4*NIBBLES-1:0]   i_b,
    output logic                   o_busy,
    output logic                   o_done,
    output logic [4*NIBBLES-1:0]   o_sum,
    output logic                   o_c_out,
    output logic                   o_ovf,
    output logic                   o_zero
);

    localparam int unsigned W     = 4 * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_accept;
    logic               w_last;

    logic [IDX_W-1:0]   r_idx;
    logic               r_carry;
    logic [W-1:0]       r_op_a;
    logic [W-1:0]       r_op_b;
    logic [W-1:0]       r_acc;

    logic [IDX_W+1:0]   w_base;
    logic [3:0]         w_nib_a;
    logic [3:0]         w_nib_b;
    logic [4:0]         w_slice;
    logic [W-1:0]       w_acc_nxt;

    logic               r_busy;
    logic               r_done;
    logic [W-1:0]       r_sum;
    logic               r_c_out;
    logic               r_ovf;
    logic               r_zero;

    // State register
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; accept is shared by IDLE and DONE for back-to-back ops
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_idx == IDX_W'(NIBBLES - 1)) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Shared 4-bit slice fed by the current nibble of each operand
    assign w_base  = {r_idx, 2'b00};
    assign w_nib_a = r_op_a[w_base +: 4];
    assign w_nib_b = r_op_b[w_base +: 4];
    assign w_slice = 5'(w_nib_a) + 5'(w_nib_b) + 5'(r_carry);

    // Accumulator including the nibble being produced this cycle
    always_comb begin
        w_acc_nxt                = r_acc;
        w_acc_nxt[w_base +: 4]   = w_slice[3:0];
    end

    // Datapath and registered outputs
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_acc   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_sum   <= '0;
            r_c_out <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            r_busy <= (w_state_nxt == S_RUN);
            r_done <= (w_state_nxt == S_DONE);
            if (w_accept) begin
                // Subtraction as a + ~b + 1: invert b once, seed carry with sub
                r_op_a  <= i_a;
                r_op_b  <= i_sub ? ~i_b : i_b;
                r_carry <= i_sub;
                r_idx   <= '0;
            end else if (r_state == S_RUN) begin
                r_acc   <= w_acc_nxt;
                r_carry <= w_slice[4];
                r_idx   <= w_last ? '0 : r_idx + IDX_W'(1);
                if (w_last) begin
                    r_sum   <= w_acc_nxt;
                    r_c_out <= w_slice[4];
                    r_ovf   <= (r_op_a[W-1] == r_op_b[W-1]) &&
                               (w_acc_nxt[W-1] != r_op_a[W-1]);
                    r_zero  <= (w_acc_nxt == '0);
                end
            end
        end
    end

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_sum   = r_sum;
    assign o_c_out = r_c_out;
    assign o_ovf   = r_ovf;
    assign o_zero  = r_zero;

endmodule

// File: tb/tb_nibble_serial_addsub.sv
// Directed bench for nibble_serial_addsub: NIBBLES=4 and NIBBLES=2 instances.
module tb_nibble_serial_addsub;

    logic        clk = 1'b0;
    logic        rst_n;

    logic        start4, sub4;
    logic [15:0] a4, b4;
    logic        busy4, done4, c4, ovf4, zero4;
    logic [15:0] sum4;

    logic        start2, sub2;
    logic [7:0]  a2, b2;
    logic        busy2, done2, c2, ovf2, zero2;
    logic [7:0]  sum2;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    nibble_serial_addsub #(.NIBBLES(4)) u_dut4 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start4), .i_sub(sub4),
        .i_a(a4), .i_b(b4), .o_busy(busy4), .o_done(done4), .o_sum(sum4),
        .o_c_out(c4), .o_ovf(ovf4), .o_zero(zero4)
    );

    nibble_serial_addsub #(.NIBBLES(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start2), .i_sub(sub2),
        .i_a(a2), .i_b(b2), .o_busy(busy2), .o_done(done2), .o_sum(sum2),
        .o_c_out(c2), .o_ovf(ovf2), .o_zero(zero2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Issue one op on the 4-nibble instance; scramble inputs during RUN
    task automatic op4(input logic [15:0] a, input logic [15:0] b, input logic s,
                       output int lat, output int nbusy);
        @(negedge clk);
        a4 = a; b4 = b; sub4 = s; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0; a4 = 16'hDEAD; b4 = 16'hBEEF; sub4 = ~s;
        lat = 1; nbusy = 0;
        while (!done4 && lat < 20) begin
            if (busy4) nbusy++;
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_res4(input string tag, input logic [15:0] s, input logic c,
                              input logic v, input logic z);
        check({tag, ".done"}, 32'(done4), 32'd1);
        check({tag, ".sum"},  32'(sum4),  32'(s));
        check({tag, ".c"},    32'(c4),    32'(c));
        check({tag, ".ovf"},  32'(ovf4),  32'(v));
        check({tag, ".zero"}, 32'(zero4), 32'(z));
    endtask

    initial begin
        int lat, nbusy, seen;
        rst_n = 1'b0;
        start4 = 1'b0; sub4 = 1'b0; a4 = '0; b4 = '0;
        start2 = 1'b0; sub2 = 1'b0; a2 = '0; b2 = '0;
        repeat (2) @(negedge clk);
        check("rst.busy", 32'(busy4), 0);
        check("rst.done", 32'(done4), 0);
        check("rst.sum",  32'(sum4),  0);
        check("rst.flags", 32'({c4, ovf4, zero4}), 0);
        rst_n = 1'b1;

        // Plain add
        op4(16'h1234, 16'h0FCD, 1'b0, lat, nbusy);
        check("add.lat", 32'(lat), 5);
        check("add.busy_cycles", 32'(nbusy), 4);
        check_res4("add", 16'h2201, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        check("add.pulse", 32'(done4), 0);
        check("add.idle", 32'(busy4), 0);
        check("add.hold", 32'(sum4), 32'h2201);

        // Wrap to zero
        op4(16'hFFFF, 16'h0001, 1'b0, lat, nbusy);
        check("wrap.lat", 32'(lat), 5);
        check_res4("wrap", 16'h0000, 1'b1, 1'b0, 1'b1);

        // Subtract with signed overflow and borrow
        op4(16'h7FFF, 16'hFFFF, 1'b1, lat, nbusy);
        check_res4("subovf", 16'h8000, 1'b0, 1'b1, 1'b0);

        // Equal subtract with start held through RUN, then back-to-back add
        @(negedge clk);
        a4 = 16'h0005; b4 = 16'h0005; sub4 = 1'b1; start4 = 1'b1;
        @(negedge clk);
        a4 = 16'h1111; b4 = 16'h2222; sub4 = 1'b0;
        lat = 1;
        while (!done4 && lat < 20) begin @(negedge clk); lat++; end
        check("eq.lat", 32'(lat), 5);
        check_res4("eq", 16'h0000, 1'b1, 1'b0, 1'b1);
        a4 = 16'h0001; b4 = 16'h0002; sub4 = 1'b0;
        @(negedge clk);
        check("b2b.busy", 32'(busy4), 1);
        check("b2b.nodone", 32'(done4), 0);
        a4 = 16'h4444; b4 = 16'h0F0F; sub4 = 1'b1;
        lat = 1;
        while (!done4 && lat < 20) begin @(negedge clk); lat++; end
        check("b2b.lat", 32'(lat), 5);
        check_res4("b2b", 16'h0003, 1'b0, 1'b0, 1'b0);
        start4 = 1'b0;
        @(negedge clk);
        check("b2b.idle", 32'({busy4, done4}), 0);

        // Reset in the middle of RUN
        @(negedge clk);
        a4 = 16'h1000; b4 = 16'h0234; sub4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("mid.busy", 32'(busy4), 0);
        check("mid.done", 32'(done4), 0);
        check("mid.sum",  32'(sum4),  0);
        check("mid.flags", 32'({c4, ovf4, zero4}), 0);
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4 || busy4) seen++;
        end
        check("mid.quiet", 32'(seen), 0);
        op4(16'h1000, 16'h0234, 1'b0, lat, nbusy);
        check("post.lat", 32'(lat), 5);
        check_res4("post", 16'h1234, 1'b0, 1'b0, 1'b0);

        // Two-nibble instance
        @(negedge clk);
        a2 = 8'h80; b2 = 8'h80; sub2 = 1'b0; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 20) begin @(negedge clk); lat++; end
        check("n2.lat",  32'(lat), 3);
        check("n2.sum",  32'(sum2), 32'h00);
        check("n2.flags", 32'({c2, ovf2, zero2}), 32'b111);
        @(negedge clk);
        a2 = 8'h10; b2 = 8'h20; sub2 = 1'b1; start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        lat = 1;
        while (!done2 && lat < 20) begin @(negedge clk); lat++; end
        check("n2sub.lat", 32'(lat), 3);
        check("n2sub.sum", 32'(sum2), 32'hF0);
        check("n2sub.flags", 32'({c2, ovf2, zero2}), 32'b000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
